// File: rtl/cell_region_reader_pkg.sv
// Shared constants, widths and FSM encoding for the cell region reader and its shadow framebuffer.
package cell_region_reader_pkg;

    localparam int XSCREEN  = 160;
    localparam int YSCREEN  = 120;
    localparam int XDIM     = 10;
    localparam int YDIM     = 10;
    localparam int COL_W    = 3;
    localparam int XW       = 8;
    localparam int YW       = 7;
    localparam int CNT_W    = 7;
    localparam int FB_DEPTH = XSCREEN * YSCREEN;
    localparam int ADDR_W   = $clog2(FB_DEPTH);
    localparam int CX_W     = $clog2(XDIM);
    localparam int CY_W     = $clog2(YDIM);

    localparam logic [COL_W-1:0] BG = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // y*160 + x as shift-add; only valid while XSCREEN is 160.
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
        logic [ADDR_W-1:0] w_y;
        w_y = ADDR_W'(y);
        return (w_y << 7) + (w_y << 5) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/cell_region_reader_shadow_fb_ram.sv
// Shadow copy of the VGA framebuffer: one write port, one registered read port,
// read-during-write to the same address returns the old contents.
module shadow_fb_ram
    import cell_region_reader_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [COL_W-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [COL_W-1:0]  o_rd_data
);

    logic [COL_W-1:0] r_mem [0:FB_DEPTH-1];
    logic [COL_W-1:0] r_rd_data;

    // Cells are stored XORed with BG, so a RAM that powers up all-zero reads back as background.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data ^ BG;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data ^ BG;

endmodule

// File: rtl/cell_region_reader.sv
// Snoops plot writes into a shadow framebuffer and reports what lies inside a
// XDIM x YDIM cell: any non-background hit, the raster-first colour, and a pixel count.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready, waiting for a query request
// ST_SCAN  | one framebuffer read per cycle across the cell, raster order
// ST_DRAIN | absorb the data of the last read (1-cycle RAM latency)
// ST_DONE  | results valid, done pulsed for one cycle
module cell_region_reader
    import cell_region_reader_pkg::*;
(
    input  logic             i_clock_50,
    input  logic             i_reset,
    input  logic             i_plot,
    input  logic [XW-1:0]    i_x,
    input  logic [YW-1:0]    i_y,
    input  logic [COL_W-1:0] i_colour,
    input  logic             i_req,
    input  logic [XW-1:0]    i_req_x,
    input  logic [YW-1:0]    i_req_y,
    output logic             o_ready,
    output logic             o_done,
    output logic             o_hit,
    output logic [COL_W-1:0] o_hit_colour,
    output logic [CNT_W-1:0] o_hit_count
);

    localparam logic [8:0] XSCREEN_9 = 9'(XSCREEN);
    localparam logic [8:0] YSCREEN_9 = 9'(YSCREEN);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [XW-1:0]     r_base_x;
    logic [YW-1:0]     r_base_y;
    logic [CX_W-1:0]   r_cx;
    logic [CY_W-1:0]   r_cy;
    logic              r_rd_qual;
    logic              r_hit;
    logic [COL_W-1:0]  r_hit_colour;
    logic [CNT_W-1:0]  r_hit_count;

    logic [8:0]        w_px;
    logic [8:0]        w_py;
    logic              w_in_screen;
    logic              w_wr_en;
    logic              w_accept;
    logic              w_scan_last;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [COL_W-1:0]  w_rd_data;

    assign w_wr_en   = i_plot && ({1'b0, i_x} < XSCREEN_9) && ({2'b0, i_y} < YSCREEN_9);
    assign w_wr_addr = fb_addr(i_x, i_y);

    // 9-bit sums so a cell hanging off the right or bottom edge never wraps into the next row.
    assign w_px        = {1'b0, r_base_x} + 9'(r_cx);
    assign w_py        = {2'b0, r_base_y} + 9'(r_cy);
    assign w_in_screen = (w_px < XSCREEN_9) && (w_py < YSCREEN_9);
    assign w_rd_addr   = w_in_screen ? fb_addr(w_px[XW-1:0], w_py[YW-1:0]) : '0;
    assign w_scan_last = (r_cx == CX_W'(XDIM - 1)) && (r_cy == CY_W'(YDIM - 1));

    shadow_fb_ram u_shadow_fb_ram (
        .i_clk     (i_clock_50),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (i_colour),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge i_clock_50) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_ready     = 1'b0;
        o_done      = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_scan_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock_50) begin
        if (i_reset) begin
            r_base_x <= '0;
            r_base_y <= '0;
            r_cx     <= '0;
            r_cy     <= '0;
        end else if (w_accept) begin
            r_base_x <= i_req_x;
            r_base_y <= i_req_y;
            r_cx     <= '0;
            r_cy     <= '0;
        end else if (r_state == ST_SCAN) begin
            if (r_cx == CX_W'(XDIM - 1)) begin
                r_cx <= '0;
                r_cy <= r_cy + 1'b1;
            end else begin
                r_cx <= r_cx + 1'b1;
            end
        end
    end

    // Qualifier travels alongside the read so it lines up with the returned pixel.
    always_ff @(posedge i_clock_50) begin
        if (i_reset) begin
            r_rd_qual <= 1'b0;
        end else begin
            r_rd_qual <= (r_state == ST_SCAN) && w_in_screen;
        end
    end

    always_ff @(posedge i_clock_50) begin
        if (i_reset || w_accept) begin
            r_hit        <= 1'b0;
            r_hit_colour <= BG;
            r_hit_count  <= '0;
        end else if (r_rd_qual && (w_rd_data != BG)) begin
            if (!r_hit) begin
                r_hit        <= 1'b1;
                r_hit_colour <= w_rd_data;
            end
            if (r_hit_count != {CNT_W{1'b1}}) begin
                r_hit_count <= r_hit_count + 1'b1;
            end
        end
    end

    assign o_hit        = r_hit;
    assign o_hit_colour = r_hit_colour;
    assign o_hit_count  = r_hit_count;

endmodule

// File: tb/tb_cell_region_reader.sv
// Scoreboard bench for cell_region_reader: a reference framebuffer model predicts each query,
// the done monitor pops and compares results and latency.
module tb_cell_region_reader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       plot = 1'b0;
    logic [7:0] x = '0;
    logic [6:0] y = '0;
    logic [2:0] colour = '0;
    logic       req = 1'b0;
    logic [7:0] req_x = '0;
    logic [6:0] req_y = '0;
    logic       ready;
    logic       done;
    logic       hit;
    logic [2:0] hit_colour;
    logic [6:0] hit_count;

    typedef struct packed {
        logic       hit;
        logic [2:0] col;
        logic [6:0] cnt;
        int         acc;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [2:0] m_fb [0:19199];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         acc;

    always #10 clk = ~clk;

    cell_region_reader dut (
        .i_clock_50   (clk),
        .i_reset      (reset),
        .i_plot       (plot),
        .i_x          (x),
        .i_y          (y),
        .i_colour     (colour),
        .i_req        (req),
        .i_req_x      (req_x),
        .i_req_y      (req_y),
        .o_ready      (ready),
        .o_done       (done),
        .o_hit        (hit),
        .o_hit_colour (hit_colour),
        .o_hit_count  (hit_count)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                check_val("unexpected_done", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("hit", hit, mon_e.hit);
                check_val("hit_colour", hit_colour, mon_e.col);
                check_val("hit_count", hit_count, mon_e.cnt);
                check_val("latency", cyc - mon_e.acc, 102);
            end
        end
    end

    function automatic exp_t model_query(input int rx, input int ry, input int a);
        exp_t e;
        int   cnt;
        int   px;
        int   py;
        cnt   = 0;
        e.hit = 1'b0;
        e.col = 3'b000;
        e.acc = a;
        for (int yy = 0; yy < 10; yy++) begin
            for (int xx = 0; xx < 10; xx++) begin
                px = rx + xx;
                py = ry + yy;
                if (px < 160 && py < 120) begin
                    if (m_fb[py*160 + px] != 3'b000) begin
                        if (cnt == 0) e.col = m_fb[py*160 + px];
                        if (cnt < 127) cnt++;
                    end
                end
            end
        end
        e.hit = (cnt != 0);
        e.cnt = cnt[6:0];
        return e;
    endfunction

    task automatic plot_px(input int px, input int py, input logic [2:0] c);
        @(negedge clk);
        plot   = 1'b1;
        x      = px[7:0];
        y      = py[6:0];
        colour = c;
        @(posedge clk);
        #1 plot = 1'b0;
        if (px < 160 && py < 120) m_fb[py*160 + px] = c;
    endtask

    task automatic start_query(input int rx, input int ry, input bit push, output int a);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check_val("ready_timeout", ready, 1);
        req   = 1'b1;
        req_x = rx[7:0];
        req_y = ry[6:0];
        a     = cyc;
        @(posedge clk);
        #1 req = 1'b0;
        if (push) sb_q.push_back(model_query(rx, ry, a));
    endtask

    task automatic wait_done();
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_val("done_seen", done_cnt - start, 1);
    endtask

    task automatic query(input int rx, input int ry);
        int a;
        start_query(rx, ry, 1'b1, a);
        wait_done();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 19200; i++) m_fb[i] = 3'b000;

        repeat (3) @(negedge clk);
        check_val("rst_ready", ready, 1);
        check_val("rst_done", done, 0);
        check_val("rst_hit", hit, 0);
        check_val("rst_colour", hit_colour, 0);
        check_val("rst_count", hit_count, 0);
        reset = 1'b0;

        // empty screen
        query(30, 30);

        // off-screen writes must not alias into the visible area
        plot_px(165, 5, 3'b111);
        plot_px(5, 125, 3'b111);
        query(0, 0);

        // solid block, full and partial overlap
        for (int j = 0; j < 10; j++)
            for (int i = 0; i < 10; i++)
                plot_px(30 + i, 30 + j, 3'b100);
        query(30, 30);
        query(35, 35);

        // raster-first colour
        plot_px(85, 42, 3'b010);
        plot_px(88, 41, 3'b001);
        query(80, 40);

        // screen corner and fully off-screen cell
        plot_px(159, 119, 3'b111);
        query(155, 115);
        query(200, 0);

        // writes during a scan: one ahead of the read pointer, one colliding with the first read
        plot_px(39, 39, 3'b000);
        start_query(30, 30, 1'b0, acc);
        sb_q.push_back('{hit: 1'b1, col: 3'b100, cnt: 7'd100, acc: acc});
        plot_px(30, 30, 3'b000);
        @(negedge clk);
        check_val("ready_in_scan", ready, 0);
        req   = 1'b1;
        req_x = 8'd0;
        req_y = 7'd0;
        repeat (3) @(negedge clk);
        req = 1'b0;
        plot_px(39, 39, 3'b010);
        wait_done();
        query(30, 30);

        // reset mid-scan
        start_query(30, 30, 1'b0, acc);
        repeat (49) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_val("abort_ready", ready, 1);
        check_val("abort_done", done, 0);
        check_val("abort_hit", hit, 0);
        check_val("abort_colour", hit_colour, 0);
        check_val("abort_count", hit_count, 0);
        repeat (150) @(negedge clk);
        query(30, 30);

        check_val("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
